multicycle_control_unit: RTL and testbench
==========================================

# multicycle_control_unit

Finite-state control unit for the multicycle build of the processor. It sequences each instruction over 3–5 cycles (fetch, decode, execute, memory, writeback) and drives the shared-memory/single-ALU datapath. It keeps the NZCV flags register and gates every architectural write with the instruction's condition field. It replaces the single-cycle decoder/conditional-logic pair and adds a memory wait handshake, so it can sit behind slow memory.

## Interface
Parameters:
- ALU_CTRL_W, 4, width of alu_ctrl; must be ≥3.
- HAS_MEM_READY, 1, 1: honour mem_ready; 0: mem_ready ignored and treated as 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- cond  in  4  instruction condition field (IR[31:28]).
- op  in  2  instruction op (IR[27:26]).
- funct  in  6  IR[25:20]: funct[5]=I, funct[4:1]=cmd, funct[0]=S/L.
- rd  in  4  destination register (IR[15:12]).
- alu_flags  in  4  {N,Z,C,V} from the ALU in the current cycle.
- mem_ready  in  1  memory access completes this cycle.
- pc_write, ir_write, reg_write, mem_write  out  1 each  write enables.
- adr_src  out  1  0=PC, 1=ALUOut as the memory address.
- alu_src_a  out  1  0=register A, 1=PC.
- alu_src_b  out  2  00=register B, 01=extended immediate, 10=constant 4.
- result_src  out  2  00=ALUOut, 01=read data, 10=ALU result direct.
- imm_src, reg_src  out  2 each  same encoding as the single-cycle datapath.
- alu_ctrl  out  ALU_CTRL_W  ALU operation: 0=ADD, 1=SUB, 2=AND, 3=ORR, 4=EOR, 5=MOV(pass B). The value is zero-extended to ALU_CTRL_W.

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH.
- FETCH: adr_src=0, alu_src_a=1, alu_src_b=10, alu_ctrl=ADD, result_src=10. ir_write and pc_write are asserted only in the cycle where mem_ready=1. The FSM stays in FETCH until that cycle, then moves to DECODE.
- DECODE: alu_src_a=1, alu_src_b=10, alu_ctrl=ADD (PC+8 for reads of R15). Next state by op:
  - op=01 → MEMADR.
  - op=00 with I=1 → EXECI; with I=0 → EXECR.
  - op=10 → BRANCH.
  - op=11 → FETCH (treated as a NOP).
- MEMADR: alu_src_b=01, alu_ctrl=ADD for U=1 (funct[3]) and SUB otherwise. Goes to MEMREAD if L=1, MEMWRITE if L=0.
- MEMREAD: adr_src=1. The FSM waits for mem_ready, then goes to MEMWB.
- MEMWB: result_src=01. reg_write=cond_ex, and pc_write=cond_ex when rd=15. Then FETCH.
- MEMWRITE: adr_src=1. mem_write=cond_ex, held until mem_ready; then FETCH.
- EXECR / EXECI: alu_src_b=00 / 01. The cmd decode is ADD 0100, SUB 0010, CMP 1010 (SUB), AND 0000, ORR 1100, EOR 0001, MOV 1101. Any other cmd behaves as MOV with reg_write suppressed. Next state is ALUWB.
- ALUWB: result_src=00. reg_write=cond_ex & ~CMP, and pc_write is additionally asserted when rd=15 (also gated by cond_ex & ~CMP). Then FETCH.
- BRANCH: alu_src_b=01, alu_ctrl=ADD, result_src=10, pc_write=cond_ex. Then FETCH.
- imm_src=op, and reg_src={op==01, op==10}, in every state.
- Flags register: updated at the end of EXECR/EXECI only, and only when S=1 and cond_ex=1.
  - N and Z are always written.
  - C and V are written only for ADD, SUB and CMP; AND, ORR, EOR and MOV leave C and V unchanged.
  - CMP always updates flags when cond_ex=1, regardless of S.
- cond_ex uses the standard ARM table (EQ … LE) evaluated on the stored flags. 1110 (AL) gives 1; 1111 gives 0.

## Timing
- Reset (asynchronous):
  - state=FETCH and flags=0000.
  - While rst=1, pc_write, ir_write, reg_write and mem_write are forced to 0. The other outputs take their FETCH values.
- The first fetch completes in the first cycle after rst falls in which mem_ready=1.
- Latency with mem_ready always 1:
  - Branch: 3 cycles.
  - Data-processing: 4 cycles.
  - Store: 4 cycles.
  - Load: 5 cycles.
  - Each extra cycle with mem_ready=0 in FETCH, MEMREAD or MEMWRITE adds one cycle.
- All outputs are combinational from state and inputs. There are no registered outputs apart from the state and flags registers.
- Flags written in EXEC are visible to cond_ex from the next cycle on. A condition therefore never depends on the flags its own instruction produces.
- A failed condition still walks the full state path, but no architectural writes occur.
- Reset asserted mid-instruction aborts it immediately, and no partial write is issued after the edge.

## Test plan
- Reset, then mem_ready=1, then ADD (op=00, I=1, cmd=0100, S=1, cond=1110). Required: states FETCH, DECODE, EXECI, ALUWB. reg_write=1 in ALUWB only. Flags are updated at the end of EXECI.
- CMP with equal operands (ALU flags 0100), followed by BNE (cond=0001). Required: Z=1 after CMP, with no reg_write. BRANCH has pc_write=0. Then BEQ gives pc_write=1.
- LDR (op=01, L=1) with mem_ready low for 2 cycles in FETCH and 3 cycles in MEMREAD. Required: total 10 cycles, and ir_write and reg_write each pulse once.
- STR with cond failing (cond=0000, Z=0). Required: mem_write stays 0 throughout MEMWRITE, and the FSM still returns to FETCH.
- MOV to rd=15 in ALUWB. Required: pc_write=1 and reg_write=1 in the same cycle.
- rst asserted during MEMWRITE with mem_ready=0. Required: mem_write drops immediately, flags=0000, state=FETCH, and no write enables while rst=1.

Source files
------------

// File: rtl/multicycle_control_unit.sv
// Multicycle control unit: sequences each instruction through fetch, decode,
// execute, memory and writeback states, owns the NZCV flags register and gates
// every architectural write with the instruction's condition field.
module multicycle_control_unit #(
    parameter int ALU_CTRL_W    = 4,
    parameter bit HAS_MEM_READY = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            cond,
    input  logic [1:0]            op,
    input  logic [5:0]            funct,
    input  logic [3:0]            rd,
    input  logic [3:0]            alu_flags,
    input  logic                  mem_ready,
    output logic                  pc_write,
    output logic                  ir_write,
    output logic                  reg_write,
    output logic                  mem_write,
    output logic                  adr_src,
    output logic                  alu_src_a,
    output logic [1:0]            alu_src_b,
    output logic [1:0]            result_src,
    output logic [1:0]            imm_src,
    output logic [1:0]            reg_src,
    output logic [ALU_CTRL_W-1:0] alu_ctrl
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_ORR = 3'd3;
    localparam logic [2:0] ALU_EOR = 3'd4;
    localparam logic [2:0] ALU_MOV = 3'd5;

    state_t     state_q, state_d;
    logic [3:0] flags_q, flags_d;
    // Condition result captured during execute so that writeback is judged on
    // the flags that existed before this instruction touched them.
    logic       cond_ex_q, cond_ex_d;

    logic       mem_rdy_s;
    logic       cond_ex_s;
    logic       cond_use_s;
    logic       rd_is_pc_s;
    logic [2:0] dp_code_s;
    logic       is_arith_s;
    logic       is_cmp_s;
    logic       cmd_known_s;
    logic [2:0] alu_code_s;
    logic       pc_write_s;
    logic       ir_write_s;
    logic       reg_write_s;
    logic       mem_write_s;

    // ARM condition table over stored {N,Z,C,V}; 1111 never executes.
    function automatic logic cond_eval(input logic [3:0] c, input logic [3:0] f);
        logic n_v, z_v, c_v, v_v, r_v;
        {n_v, z_v, c_v, v_v} = f;
        case (c)
            4'b0000: r_v = z_v;
            4'b0001: r_v = ~z_v;
            4'b0010: r_v = c_v;
            4'b0011: r_v = ~c_v;
            4'b0100: r_v = n_v;
            4'b0101: r_v = ~n_v;
            4'b0110: r_v = v_v;
            4'b0111: r_v = ~v_v;
            4'b1000: r_v = c_v & ~z_v;
            4'b1001: r_v = ~c_v | z_v;
            4'b1010: r_v = (n_v == v_v);
            4'b1011: r_v = (n_v != v_v);
            4'b1100: r_v = ~z_v & (n_v == v_v);
            4'b1101: r_v = z_v | (n_v != v_v);
            4'b1110: r_v = 1'b1;
            default: r_v = 1'b0;
        endcase
        return r_v;
    endfunction

    assign mem_rdy_s  = HAS_MEM_READY ? mem_ready : 1'b1;
    assign cond_ex_s  = cond_eval(cond, flags_q);
    assign cond_use_s = (state_q == S_ALUWB) ? cond_ex_q : cond_ex_s;
    assign rd_is_pc_s = (rd == 4'hF);

    // Data-processing command decode; unknown commands act as MOV without writeback.
    always_comb begin
        dp_code_s   = ALU_MOV;
        is_arith_s  = 1'b0;
        is_cmp_s    = 1'b0;
        cmd_known_s = 1'b1;
        case (funct[4:1])
            4'b0100: begin dp_code_s = ALU_ADD; is_arith_s = 1'b1; end
            4'b0010: begin dp_code_s = ALU_SUB; is_arith_s = 1'b1; end
            4'b1010: begin dp_code_s = ALU_SUB; is_arith_s = 1'b1; is_cmp_s = 1'b1; end
            4'b0000: dp_code_s = ALU_AND;
            4'b1100: dp_code_s = ALU_ORR;
            4'b0001: dp_code_s = ALU_EOR;
            4'b1101: dp_code_s = ALU_MOV;
            default: begin dp_code_s = ALU_MOV; cmd_known_s = 1'b0; end
        endcase
    end

    // Next-state logic; memory-facing states hold until the access completes.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: begin
                if (mem_rdy_s) state_d = S_DECODE;
                else           state_d = S_FETCH;
            end
            S_DECODE: begin
                case (op)
                    2'b01:   state_d = S_MEMADR;
                    2'b00:   state_d = funct[5] ? S_EXECI : S_EXECR;
                    2'b10:   state_d = S_BRANCH;
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                if (funct[0]) state_d = S_MEMREAD;
                else          state_d = S_MEMWRITE;
            end
            S_MEMREAD: begin
                if (mem_rdy_s) state_d = S_MEMWB;
                else           state_d = S_MEMREAD;
            end
            S_MEMWRITE: begin
                if (mem_rdy_s) state_d = S_FETCH;
                else           state_d = S_MEMWRITE;
            end
            S_EXECR, S_EXECI: state_d = S_ALUWB;
            S_MEMWB, S_ALUWB, S_BRANCH: state_d = S_FETCH;
            default: state_d = S_FETCH;
        endcase
    end

    // Flags and captured condition: both change only at the end of execute.
    always_comb begin
        flags_d   = flags_q;
        cond_ex_d = cond_ex_q;
        if ((state_q == S_EXECR) || (state_q == S_EXECI)) begin
            cond_ex_d = cond_ex_s;
            if (cond_ex_s && (funct[0] || is_cmp_s)) begin
                flags_d[3:2] = alu_flags[3:2];
                if (is_arith_s) flags_d[1:0] = alu_flags[1:0];
                else            flags_d[1:0] = flags_q[1:0];
            end else begin
                flags_d = flags_q;
            end
        end else begin
            cond_ex_d = cond_ex_q;
        end
    end

    // State, flags and captured condition registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_FETCH;
            flags_q   <= 4'b0000;
            cond_ex_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            flags_q   <= flags_d;
            cond_ex_q <= cond_ex_d;
        end
    end

    // Datapath controls and ungated write enables decoded from the current state.
    always_comb begin
        pc_write_s  = 1'b0;
        ir_write_s  = 1'b0;
        reg_write_s = 1'b0;
        mem_write_s = 1'b0;
        adr_src     = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        result_src  = 2'b00;
        alu_code_s  = ALU_ADD;
        case (state_q)
            S_FETCH: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_write_s = mem_rdy_s;
                pc_write_s = mem_rdy_s;
            end
            S_DECODE: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEMADR: begin
                alu_src_b  = 2'b01;
                alu_code_s = funct[3] ? ALU_ADD : ALU_SUB;
            end
            S_MEMREAD: adr_src = 1'b1;
            S_MEMWB: begin
                result_src  = 2'b01;
                reg_write_s = cond_use_s;
                pc_write_s  = cond_use_s & rd_is_pc_s;
            end
            S_MEMWRITE: begin
                adr_src     = 1'b1;
                mem_write_s = cond_use_s;
            end
            S_EXECR: begin
                alu_src_b  = 2'b00;
                alu_code_s = dp_code_s;
            end
            S_EXECI: begin
                alu_src_b  = 2'b01;
                alu_code_s = dp_code_s;
            end
            S_ALUWB: begin
                result_src  = 2'b00;
                reg_write_s = cond_use_s & ~is_cmp_s & cmd_known_s;
                pc_write_s  = cond_use_s & ~is_cmp_s & cmd_known_s & rd_is_pc_s;
            end
            S_BRANCH: begin
                alu_src_b  = 2'b01;
                result_src = 2'b10;
                pc_write_s = cond_use_s;
            end
            default: begin
                alu_code_s = ALU_ADD;
            end
        endcase
    end

    // Reset suppresses every write enable asynchronously.
    assign pc_write  = pc_write_s  & ~rst;
    assign ir_write  = ir_write_s  & ~rst;
    assign reg_write = reg_write_s & ~rst;
    assign mem_write = mem_write_s & ~rst;

    assign alu_ctrl = ALU_CTRL_W'(alu_code_s);
    assign imm_src  = op;
    assign reg_src  = {op == 2'b01, op == 2'b10};

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: stimulus pushes the expected control
// vector of every cycle into a queue; a negedge monitor pops and compares.
module tb_multicycle_control_unit;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [3:0]   cond = 4'h0;
    logic [1:0]   op = 2'b00;
    logic [5:0]   funct = 6'h00;
    logic [3:0]   rd = 4'h0;
    logic [3:0]   alu_flags = 4'h0;
    logic         mem_ready = 1'b0;
    logic         pc_write, ir_write, reg_write, mem_write, adr_src, alu_src_a;
    logic [1:0]   alu_src_b, result_src, imm_src, reg_src;
    logic [W-1:0] alu_ctrl;

    typedef struct packed {
        logic       pcw, irw, rw, mw, adr, srca;
        logic [1:0] srcb, ress, imm, regs;
        logic [3:0] aluc;
    } exp_t;

    exp_t       exp_q[$];
    string      tag_q[$];
    int         total = 0;
    int         bad = 0;
    int         obs_irw = 0;
    int         obs_rw = 0;
    logic [3:0] mflags = 4'h0;
    exp_t       act_v, exp_v;
    string      tag_v;

    always #5 clk = ~clk;

    multicycle_control_unit #(.ALU_CTRL_W(W), .HAS_MEM_READY(1'b1)) dut (
        .clk(clk), .rst(rst), .cond(cond), .op(op), .funct(funct), .rd(rd),
        .alu_flags(alu_flags), .mem_ready(mem_ready),
        .pc_write(pc_write), .ir_write(ir_write), .reg_write(reg_write),
        .mem_write(mem_write), .adr_src(adr_src), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .result_src(result_src), .imm_src(imm_src),
        .reg_src(reg_src), .alu_ctrl(alu_ctrl)
    );

    // Monitor: compare the DUT control vector against the next expected entry.
    always @(negedge clk) begin
        act_v = {pc_write, ir_write, reg_write, mem_write, adr_src, alu_src_a,
                 alu_src_b, result_src, imm_src, reg_src, alu_ctrl};
        if (ir_write === 1'b1) obs_irw++;
        if (reg_write === 1'b1) obs_rw++;
        if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            tag_v = tag_q.pop_front();
            total++;
            if (act_v !== exp_v) begin
                bad++;
                $display("FAIL %s @%0t: got %05h want %05h", tag_v, $time, act_v, exp_v);
            end
        end
    end

    // Reference condition check: base test on cond[3:1], odd codes invert it.
    function automatic bit cond_holds(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cy, v, r;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c[3:1])
            3'd0: r = z;
            3'd1: r = cy;
            3'd2: r = n;
            3'd3: r = v;
            3'd4: r = cy && !z;
            3'd5: r = (n == v);
            3'd6: r = !z && (n == v);
            default: r = 1'b1;
        endcase
        return c[0] ? !r : r;
    endfunction

    // Reference command table: ALU code and flag/writeback behaviour.
    function automatic void cmd_model(input logic [3:0] cmd, output logic [3:0] aluc,
                                      output bit arith, output bit cmp, output bit known);
        arith = 1'b0; cmp = 1'b0; known = 1'b1;
        if (cmd == 4'b0100)      begin aluc = 4'd0; arith = 1'b1; end
        else if (cmd == 4'b0010) begin aluc = 4'd1; arith = 1'b1; end
        else if (cmd == 4'b1010) begin aluc = 4'd1; arith = 1'b1; cmp = 1'b1; end
        else if (cmd == 4'b0000) aluc = 4'd2;
        else if (cmd == 4'b1100) aluc = 4'd3;
        else if (cmd == 4'b0001) aluc = 4'd4;
        else if (cmd == 4'b1101) aluc = 4'd5;
        else begin aluc = 4'd5; known = 1'b0; end
    endfunction

    function automatic exp_t vbase(input logic [1:0] o);
        exp_t e;
        e = '0;
        e.imm = o;
        e.regs = {o == 2'b01, o == 2'b10};
        return e;
    endfunction

    function automatic exp_t vfetch(input logic [1:0] o, input logic done);
        exp_t e;
        e = vbase(o);
        e.srca = 1'b1; e.srcb = 2'b10; e.ress = 2'b10;
        e.pcw = done; e.irw = done;
        return e;
    endfunction

    task automatic cycle(input exp_t e, input string tag, input logic mr, input logic [3:0] af);
        mem_ready = mr;
        alu_flags = af;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        mflags = 4'h0;
        for (int i = 0; i < n; i++) cycle(vfetch(op, 1'b0), "reset", 1'b1, 4'($urandom));
        rst = 1'b0;
    endtask

    task automatic run_instr(input logic [3:0] c, input logic [1:0] o, input logic [5:0] f,
                             input logic [3:0] d, input int fst, input int mst,
                             input logic [3:0] xf);
        exp_t e; bit ce, ar, cm, kn; logic [3:0] ac;
        cond = c; op = o; funct = f; rd = d;
        ce = cond_holds(c, mflags);
        for (int i = 0; i < fst; i++) cycle(vfetch(o, 1'b0), "fetch_wait", 1'b0, 4'($urandom));
        cycle(vfetch(o, 1'b1), "fetch", 1'b1, 4'($urandom));
        e = vbase(o); e.srca = 1'b1; e.srcb = 2'b10;
        cycle(e, "decode", 1'($urandom), 4'($urandom));
        case (o)
            2'b10: begin
                e = vbase(o); e.srcb = 2'b01; e.ress = 2'b10; e.pcw = ce;
                cycle(e, "branch", 1'($urandom), 4'($urandom));
            end
            2'b01: begin
                e = vbase(o); e.srcb = 2'b01; e.aluc = f[3] ? 4'd0 : 4'd1;
                cycle(e, "memadr", 1'($urandom), 4'($urandom));
                if (f[0]) begin
                    e = vbase(o); e.adr = 1'b1;
                    for (int i = 0; i < mst; i++) cycle(e, "memread_wait", 1'b0, 4'($urandom));
                    cycle(e, "memread", 1'b1, 4'($urandom));
                    e = vbase(o); e.ress = 2'b01; e.rw = ce; e.pcw = ce && (d == 4'hF);
                    cycle(e, "memwb", 1'($urandom), 4'($urandom));
                end else begin
                    e = vbase(o); e.adr = 1'b1; e.mw = ce;
                    for (int i = 0; i < mst; i++) cycle(e, "memwrite_wait", 1'b0, 4'($urandom));
                    cycle(e, "memwrite", 1'b1, 4'($urandom));
                end
            end
            2'b00: begin
                cmd_model(f[4:1], ac, ar, cm, kn);
                e = vbase(o); e.srcb = f[5] ? 2'b01 : 2'b00; e.aluc = ac;
                cycle(e, "exec", 1'($urandom), xf);
                if (ce && (f[0] || cm)) begin
                    mflags[3:2] = xf[3:2];
                    if (ar) mflags[1:0] = xf[1:0];
                end
                e = vbase(o); e.rw = ce && !cm && kn; e.pcw = e.rw && (d == 4'hF);
                cycle(e, "aluwb", 1'($urandom), 4'($urandom));
            end
            default: ;
        endcase
    endtask

    initial begin
        exp_t e;
        int irw0, rw0;
        @(posedge clk);
        #1;
        do_reset(2);

        // ADDS immediate, always; flags N,C,V set, then BMI must branch
        run_instr(4'hE, 2'b00, 6'b101001, 4'h3, 0, 0, 4'b1011);
        run_instr(4'h4, 2'b10, 6'h00, 4'h0, 0, 0, 4'h0);
        // CMP without S bit, equal operands; BNE not taken, BEQ taken
        run_instr(4'hE, 2'b00, 6'b010100, 4'h1, 0, 0, 4'b0100);
        run_instr(4'h1, 2'b10, 6'h00, 4'h0, 0, 0, 4'h0);
        run_instr(4'h0, 2'b10, 6'h00, 4'h0, 0, 0, 4'h0);

        // LDR with 2 fetch and 3 read wait cycles: one IR and one reg write
        irw0 = obs_irw; rw0 = obs_rw;
        run_instr(4'hE, 2'b01, 6'b111001, 4'h5, 2, 3, 4'h0);
        total++;
        if (obs_irw - irw0 != 1) begin bad++; $display("FAIL ldr_ir_pulses: got %0d want 1", obs_irw - irw0); end
        total++;
        if (obs_rw - rw0 != 1) begin bad++; $display("FAIL ldr_reg_pulses: got %0d want 1", obs_rw - rw0); end

        // Clear Z, then STREQ must walk MEMWRITE without writing
        run_instr(4'hE, 2'b00, 6'b010100, 4'h1, 0, 0, 4'b0000);
        run_instr(4'h0, 2'b01, 6'b011000, 4'h2, 0, 2, 4'h0);
        // MOV to PC: reg_write and pc_write together
        run_instr(4'hE, 2'b00, 6'b011010, 4'hF, 0, 0, 4'h0);

        // Set Z, start a store, reset while the write waits on memory
        run_instr(4'hE, 2'b00, 6'b010100, 4'h1, 0, 0, 4'b0100);
        cond = 4'hE; op = 2'b01; funct = 6'b011000; rd = 4'h2;
        cycle(vfetch(2'b01, 1'b1), "pre_fetch", 1'b1, 4'h0);
        e = vbase(2'b01); e.srca = 1'b1; e.srcb = 2'b10;
        cycle(e, "pre_decode", 1'b1, 4'h0);
        e = vbase(2'b01); e.srcb = 2'b01;
        cycle(e, "pre_memadr", 1'b1, 4'h0);
        e = vbase(2'b01); e.adr = 1'b1; e.mw = 1'b1;
        cycle(e, "pre_memwrite", 1'b0, 4'h0);
        do_reset(2);
        // Flags cleared by reset: BEQ must not branch
        run_instr(4'h0, 2'b10, 6'h00, 4'h0, 1, 0, 4'h0);

        for (int k = 0; k < 150; k++) begin
            if ($urandom_range(0, 59) == 0) do_reset(1);
            run_instr($urandom_range(0, 1) ? 4'hE : 4'($urandom_range(0, 15)),
                      2'($urandom), 6'($urandom),
                      ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom),
                      $urandom_range(0, 2), $urandom_range(0, 2), 4'($urandom));
        end

        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
